// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants for the program loader and the decoder side.
package instr_pkg;

  // Symbolic operation classes; values 10..15 are illegal requests.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLT = 4'd4,
    OP_LW  = 4'd5,
    OP_SW  = 4'd6,
    OP_BEQ = 4'd7,
    OP_BNE = 4'd8,
    OP_J   = 4'd9
  } op_e;

  // Primary opcode field, bits [31:26].
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;

  // R-type function field, bits [5:0].
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] SHAMT_ZERO = 5'd0;
  localparam logic [3:0] OP_LAST    = 4'd9;

  // Anything above J is an op the encoder does not know.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

  // R-type word with the given function code.
  function automatic logic [31:0] pack_rtype(input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd,
                                             input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, SHAMT_ZERO, fn};
  endfunction

  // I-type word (loads, stores, branches).
  function automatic logic [31:0] pack_itype(input logic [5:0]  opc,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Full encoder; fields an op does not use are simply not referenced.
  // Illegal ops yield zero, but the caller never stores them.
  function automatic logic [31:0] encode_instr(input logic [3:0]  op,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [4:0]  rd,
                                               input logic [15:0] imm,
                                               input logic [25:0] target);
    logic [31:0] word;
    word = 32'd0;
    case (op_e'(op))
      OP_ADD:  word = pack_rtype(rs, rt, rd, FN_ADD);
      OP_SUB:  word = pack_rtype(rs, rt, rd, FN_SUB);
      OP_AND:  word = pack_rtype(rs, rt, rd, FN_AND);
      OP_OR:   word = pack_rtype(rs, rt, rd, FN_OR);
      OP_SLT:  word = pack_rtype(rs, rt, rd, FN_SLT);
      OP_LW:   word = pack_itype(OPC_LW,  rs, rt, imm);
      OP_SW:   word = pack_itype(OPC_SW,  rs, rt, imm);
      OP_BEQ:  word = pack_itype(OPC_BEQ, rs, rt, imm);
      OP_BNE:  word = pack_itype(OPC_BNE, rs, rt, imm);
      OP_J:    word = {OPC_J, target};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and no write-through:
// a word pushed this cycle is visible at the head only from the next cycle,
// and a full FIFO refuses a push even if it pops in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Next pointers, occupancy and flags from this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
  end

  // Control state: reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are meaningless while empty, so never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction requests into MIPS words, buffers them and
// writes them to consecutive instruction-memory addresses.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_illegal,
  output logic              wrap,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic        accept, legal, push, pop;
  logic [31:0] enc_word;
  logic [31:0] head_word;
  logic        fifo_full, fifo_empty;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  // Request side: encode at enqueue, drop illegal ops after the handshake.
  assign in_ready = !rst && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign legal    = is_legal_op(in_op);
  assign push     = accept && legal;
  assign enc_word = encode_instr(in_op, in_rs, in_rt, in_rd, in_imm, in_target);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (enc_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Memory side: the head word is offered until the memory takes it.
  assign mem_we    = !fifo_empty;
  assign pop       = mem_we && mem_ready;
  assign mem_wdata = fifo_empty ? 32'd0 : head_word;
  assign mem_addr  = addr_q;
  assign busy      = !fifo_empty;
  assign wrap      = wrap_q;
  assign err_illegal = err_q;

  // Address advance and one-cycle status pulses.
  always_comb begin
    addr_d = addr_q;
    wrap_d = pop && (addr_q == ADDR_LAST);
    err_d  = accept && !legal;
    if (pop) addr_d = addr_q + ADDR_ONE;
  end

  // Address counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= BASE_ADDR;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: queue-based model plus directed scenarios
// and a randomized phase; an 8-bit and a 2-bit address instance share stimulus.
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        mem_ready;

  logic        in_ready, mem_we, err_illegal, wrap, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        in_ready2, mem_we2, err_illegal2, wrap2, busy2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err_illegal(err_illegal), .wrap(wrap), .busy(busy)
  );

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we2),
    .mem_ready(mem_ready), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .err_illegal(err_illegal2), .wrap(wrap2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding from the instruction-format rules.
  function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt,
                                          input int rd, input int imm, input int tgt);
    logic [31:0] r, i;
    int fn;
    r = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
    i = (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm & 16'hFFFF);
    fn = 0;
    case (op)
      0: fn = 32;
      1: fn = 34;
      2: fn = 36;
      3: fn = 37;
      4: fn = 42;
      default: fn = 0;
    endcase
    case (op)
      0, 1, 2, 3, 4: return r | 32'(fn);
      5: return (32'd35 << 26) | i;
      6: return (32'd43 << 26) | i;
      7: return (32'd4 << 26) | i;
      8: return (32'd5 << 26) | i;
      9: return (32'd2 << 26) | 32'(tgt & 32'h03FFFFFF);
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural model state.
  logic [31:0] q[$];
  int  m_addr, m_addr2;
  bit  m_err, m_wrap, m_wrap2;
  bit  started = 0;
  int  writes_seen = 0, err_seen = 0, wrap2_seen = 0, wrap_seen = 0;

  // Model advances on every rising edge from the inputs the DUT sampled.
  always @(posedge clk) begin
    bit rdy, acc, pp;
    if (rst) begin
      q.delete();
      m_addr = 0; m_addr2 = 0;
      m_err = 0; m_wrap = 0; m_wrap2 = 0;
      started = 1;
    end else if (started) begin
      rdy = (q.size() < DEPTH);
      acc = in_valid && rdy;
      pp  = (q.size() > 0) && mem_ready;
      m_err   = acc && (in_op > 4'd9);
      m_wrap  = pp && (m_addr == 255);
      m_wrap2 = pp && (m_addr2 == 3);
      if (pp) begin
        void'(q.pop_front());
        m_addr  = (m_addr + 1) % 256;
        m_addr2 = (m_addr2 + 1) % 4;
      end
      if (acc && in_op <= 4'd9)
        q.push_back(ref_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                            int'(in_imm), int'(in_target)));
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (started) begin
      exp_w = (q.size() > 0) ? q[0] : 32'd0;
      chk("in_ready",  in_ready,  !rst && (q.size() < DEPTH));
      chk("mem_we",    mem_we,    q.size() > 0);
      chk("busy",      busy,      q.size() > 0);
      chk("mem_wdata", mem_wdata, exp_w);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("err",       err_illegal, m_err);
      chk("wrap",      wrap,      m_wrap);
      chk("in_ready2", in_ready2, !rst && (q.size() < DEPTH));
      chk("mem_we2",   mem_we2,   q.size() > 0);
      chk("wdata2",    mem_wdata2, exp_w);
      chk("mem_addr2", mem_addr2, m_addr2);
      chk("err2",      err_illegal2, m_err);
      chk("wrap2",     wrap2,     m_wrap2);
      if (mem_we && mem_ready) writes_seen++;
      if (err_illegal) err_seen++;
      if (wrap) wrap_seen++;
      if (wrap2) wrap2_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int op, input int rs, input int rt, input int rd,
                         input int imm, input int tgt);
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt);
  endtask

  // Hold a request until the handshake completes (bounded).
  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int imm, input int tgt);
    bit r;
    bit done;
    set_req(op, rs, rt, rd, imm, tgt);
    in_valid = 1'b1;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      r = in_ready;
      step();
      if (r) done = 1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] exp_tab [4];
  int w0, e0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);

    // Pin the reference encoder with hand-computed words.
    chk("enc_add", ref_enc(0, 1, 2, 3, 0, 0), 32'h00221820);
    chk("enc_lw",  ref_enc(5, 29, 8, 0, 4, 0), 32'h8FA80004);
    chk("enc_beq", ref_enc(7, 1, 2, 0, 16'hFFFF, 0), 32'h1022FFFF);
    chk("enc_j",   ref_enc(9, 0, 0, 0, 0, 16), 32'h08000010);
    chk("enc_slt", ref_enc(4, 4, 5, 6, 0, 0), 32'h0085302A);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 8'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    step();
    rst = 1'b0;

    // Single ADD with memory ready.
    mem_ready = 1'b1;
    set_req(0, 1, 2, 3, 0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_we", mem_we, 1'b1);
    chk("add_addr", mem_addr, 8'd0);
    chk("add_wdata", mem_wdata, 32'h00221820);
    step();
    @(negedge clk);
    chk("add_next_addr", mem_addr, 8'd1);
    chk("add_idle_we", mem_we, 1'b0);

    // Back-to-back mixed ops, one word per cycle.
    do_reset();
    exp_tab[0] = 32'h8FA80004; exp_tab[1] = 32'h1022FFFF;
    exp_tab[2] = 32'h08000010; exp_tab[3] = 32'h0085302A;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_req(5, 29, 8, 0, 4, 0);
        1: set_req(7, 1, 2, 0, 16'hFFFF, 0);
        2: set_req(9, 0, 0, 0, 0, 16);
        default: set_req(4, 4, 5, 6, 0, 0);
      endcase
      in_valid = 1'b1;
      step();
      @(negedge clk);
      chk("b2b_wdata", mem_wdata, exp_tab[i]);
      chk("b2b_addr", mem_addr, 32'(i));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: four fill the FIFO, the fifth waits.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1, 2, i + 1, 0, 0);
    set_req(0, 1, 2, 5, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", in_ready, 1'b0);
      chk("hold_addr", mem_addr, 8'd0);
      chk("hold_wdata", mem_wdata, 32'h00220820);
      step();
    end
    mem_ready = 1'b1;
    w0 = writes_seen;
    send(0, 1, 2, 5, 0, 0);
    repeat (8) step();
    chk("bp_total_writes", writes_seen - w0 + 0, 32'd5);
    chk("bp_final_addr", mem_addr, 8'd5);

    // Illegal op between two legal ones.
    do_reset();
    w0 = writes_seen; e0 = err_seen;
    send(1, 3, 4, 5, 0, 0);
    send(12, 7, 7, 7, 7, 7);
    send(3, 6, 7, 8, 0, 0);
    repeat (4) step();
    chk("ill_err_pulses", err_seen - e0, 32'd1);
    chk("ill_writes", writes_seen - w0, 32'd2);
    chk("ill_addr", mem_addr, 8'd2);

    // Two-bit address instance wraps after four words.
    do_reset();
    e0 = wrap2_seen;
    for (int i = 0; i < 5; i++) send(2, i, i + 1, i + 2, 0, 0);
    repeat (4) step();
    chk("wrap2_pulses", wrap2_seen - e0, 32'd1);
    chk("wrap2_addr", mem_addr2, 2'd1);

    // Reset while three words are pending.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(6, i, i, 0, i, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_we", mem_we, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", mem_addr, 8'd0);
    mem_ready = 1'b1;
    w0 = writes_seen;
    repeat (6) step();
    chk("midrst_no_stale", writes_seen - w0, 32'd0);

    // Randomized traffic, long enough to wrap the 8-bit address.
    do_reset();
    e0 = wrap_seen;
    for (int c = 0; c < 1400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_op     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      if (c == 700) rst = 1'b1;
      else rst = 1'b0;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (8) step();
    if (wrap_seen == e0) chk("rand_wrap_seen", 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Assembler-side counterpart to the control/ALU-control decoder. It accepts symbolic instruction requests (operation class plus register, immediate and target fields) on a valid/ready stream and packs each one into a 32-bit MIPS instruction word. It buffers encoded words in a small FIFO and writes them sequentially into instruction memory through a held-until-accepted write handshake. It is used by the bench and boot path to load programs that the decoder later consumes.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  block can accept request
in_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 LW,6 SW,7 BEQ,8 BNE,9 J,10-15 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R-type only)
in_imm  in  16  immediate/offset (LW,SW,BEQ,BNE)
in_target  in  26  jump target (J)
mem_we  out  1  write request valid
mem_ready  in  1  memory accepts write
mem_addr  out  ADDR_W  word address of current write
mem_wdata  out  32  encoded instruction
err_illegal  out  1  one-cycle pulse, illegal op dropped
wrap  out  1  one-cycle pulse when address wraps to 0
busy  out  1  FIFO non-empty

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. Reset values: in_ready=0 during rst, then 1; mem_we=0; mem_wdata=0; mem_addr=BASE_ADDR; err_illegal=0; wrap=0; busy=0. FIFO is emptied.
- Reset mid-operation: pending FIFO words are discarded; a held mem_we drops on the cycle after rst is sampled.
- Accept: transfer occurs when in_valid && in_ready. in_ready = !rst && FIFO not full. There is no bypass, so a full FIFO stays not-ready even if a dequeue happens in the same cycle.
- Encoding is combinational at enqueue; the FIFO stores 32-bit words.
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}. funct is ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}. SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}. BNE: {000101, rs, rt, imm}.
  - J: {000010, target}.
  - Fields not used by an op are ignored.
- Illegal op (10-15): the request is accepted (handshake completes), not enqueued, and err_illegal pulses one cycle later.
- Drain: whenever the FIFO is non-empty, mem_we=1 and mem_wdata=head word. mem_addr, mem_wdata and mem_we are held stable until mem_ready.
  - On mem_we && mem_ready: pop the head and set mem_addr = mem_addr+1 (mod 2^ADDR_W).
  - On the step from 2^ADDR_W-1 to 0, wrap pulses one cycle and writing continues.
- Latency: a word accepted in cycle N appears on mem_we/mem_wdata in cycle N+1 at the earliest. With mem_ready held high, throughput is 1 word/cycle.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged.
- busy = FIFO non-empty, registered with the FIFO state.

Decomposition:
- Shared package instr_pkg holds:
  - the op enum (4-bit, values above)
  - opcode constants OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_J
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT
- The same constants are reused by the decoder side.
- One sub-module, sync_fifo (DEPTH x 32, registered full/empty, no bypass). Encoding and address counter live in the top.

Test Plan:
- Reset, then ADD rs=1 rt=2 rd=3 with mem_ready=1 -> mem_we one cycle later, mem_addr=0, mem_wdata=0x00221820; next addr 1.
- Back-to-back LW rt=8 rs=29 imm=0x0004; BEQ rs=1 rt=2 imm=0xFFFF; J target=0x10; SLT rs=4 rt=5 rd=6 -> words 0x8FA80004, 0x1022FFFF, 0x08000010, 0x0085302A at addrs 0-3, one per cycle.
- mem_ready=0, push 5 ADDs -> in_ready low after 4 accepted; addr/data held stable. Raise mem_ready -> 5th accepted, all 5 written in order.
- op=12 between two valid ops -> err_illegal pulses once, only 2 words written, at consecutive addresses.
- ADDR_W=2: write 5 words -> addresses 0,1,2,3,0, with wrap pulse on the 3->0 step.
- Assert rst while 3 words are pending and mem_ready=0 -> mem_we=0 next cycle, busy=0, mem_addr=BASE_ADDR, and no stale word is written afterward.
